// File: rtl/uart_cmd_decoder_if.sv
// Byte-in / command-out bundle for uart_cmd_decoder; slave is the decoder, master the byte source and consumer.
// The command side is valid/ready; the byte side is a level-valid that the decoder edge-detects.
interface uart_cmd_decoder_if;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_cmd_valid;
    logic        i_cmd_ready;
    logic        o_cmd_write;
    logic [7:0]  o_cmd_addr;
    logic [31:0] o_cmd_wdata;
    logic        o_err;
    logic [1:0]  o_err_code;

    modport slave (
        input  i_rx_valid, i_rx_data, i_cmd_ready,
        output o_cmd_valid, o_cmd_write, o_cmd_addr, o_cmd_wdata, o_err, o_err_code
    );

    modport master (
        output i_rx_valid, i_rx_data, i_cmd_ready,
        input  o_cmd_valid, o_cmd_write, o_cmd_addr, o_cmd_wdata, o_err, o_err_code
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes A5-framed UART read/write commands; o_cmd_valid rises one cycle after the final byte's strobe.
// Command held until i_cmd_ready; bytes arriving while a command is pending are dropped with an overrun error.
module uart_cmd_decoder #(
    parameter int timeout_cycles = 30000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    uart_cmd_decoder_if.slave  bus
);
    localparam int CW = $clog2(timeout_cycles + 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [1:0] ERR_BAD   = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_OVR   = 2'b11;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD} state_t;

    state_t          state_q, state_d;
    logic            rx_vld_prev_q, rx_vld_prev_d;
    logic            cmd_write_q, cmd_write_d;
    logic [7:0]      cmd_addr_q, cmd_addr_d;
    logic [31:0]     cmd_wdata_q, cmd_wdata_d;
    logic [1:0]      idx_q, idx_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic strobe;
    logic in_frame;
    logic tmo_hit;

    assign strobe   = bus.i_rx_valid & ~rx_vld_prev_q;
    assign in_frame = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    assign tmo_hit  = (tmo_cnt_q == CW'(timeout_cycles - 1));

    always_comb begin
        state_d       = state_q;
        rx_vld_prev_d = bus.i_rx_valid;
        cmd_write_d   = cmd_write_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_wdata_d   = cmd_wdata_q;
        idx_d         = idx_q;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
        tmo_cnt_d     = '0;

        case (state_q)
            IDLE: begin
                if (strobe && (bus.i_rx_data == SYNC_BYTE)) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (strobe) begin
                    if ((bus.i_rx_data == CMD_WR) || (bus.i_rx_data == CMD_RD)) begin
                        cmd_write_d = (bus.i_rx_data == CMD_WR);
                        state_d     = ADDR;
                    end else begin
                        state_d    = IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD;
                    end
                end
            end
            ADDR: begin
                if (strobe) begin
                    cmd_addr_d = bus.i_rx_data;
                    if (cmd_write_q) begin
                        idx_d   = 2'd0;
                        state_d = DATA;
                    end else begin
                        cmd_wdata_d = '0;
                        state_d     = HOLD;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    cmd_wdata_d[{idx_q, 3'b000} +: 8] = bus.i_rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // A byte landing here is lost even if the transfer completes this cycle.
                if (strobe) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVR;
                end
                if (bus.i_cmd_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A strobe restarts the inter-byte window, so it always beats a timeout.
        if (in_frame && !strobe) begin
            if (tmo_hit) begin
                state_d    = IDLE;
                err_d      = 1'b1;
                err_code_d = ERR_TMO;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            rx_vld_prev_q <= 1'b1;
            cmd_write_q   <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= '0;
            idx_q         <= '0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            rx_vld_prev_q <= rx_vld_prev_d;
            cmd_write_q   <= cmd_write_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            idx_q         <= idx_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign bus.o_cmd_valid = (state_q == HOLD);
    assign bus.o_cmd_write = cmd_write_q;
    assign bus.o_cmd_addr  = cmd_addr_q;
    assign bus.o_cmd_wdata = cmd_wdata_q;
    assign bus.o_err       = err_q;
    assign bus.o_err_code  = err_code_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: expected commands are queued when frames are sent and
// checked as each valid/ready transfer occurs; error pulses are collected and checked per step.
module tb_uart_cmd_decoder;
    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(.timeout_cycles(100)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  vld;
    } exp_t;

    int         n_cmp  = 0;
    int         n_fail = 0;
    exp_t       sb[$];
    logic [1:0] err_seen[$];
    int         vld_run  = 0;
    logic       err_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor at the falling edge, then return 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge i_clk);
        if (bus.o_err === 1'b1) begin
            chk("err_one_cycle", {63'd0, err_prev}, 64'd0);
            err_seen.push_back(bus.o_err_code);
        end
        err_prev = bus.o_err;
        if (bus.o_cmd_valid === 1'b1) begin
            vld_run++;
            if (bus.i_cmd_ready === 1'b1) begin
                chk("cmd_expected", {63'd0, sb.size() > 0}, 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("cmd_write", {63'd0, bus.o_cmd_write}, {63'd0, e.wr});
                    chk("cmd_addr", {56'd0, bus.o_cmd_addr}, {56'd0, e.addr});
                    chk("cmd_wdata", {32'd0, bus.o_cmd_wdata}, {32'd0, e.wdata});
                    if (e.vld != 8'd0) begin
                        chk("valid_cycles", 64'(vld_run), {56'd0, e.vld});
                    end
                end
                vld_run = 0;
            end
        end else begin
            vld_run = 0;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        repeat (hold) tick();
        bus.i_rx_valid = 1'b0;
        tick();
    endtask

    task automatic send_write(input logic [7:0] a, input logic [31:0] d, input logic [7:0] vld, input int hold);
        sb.push_back('{wr: 1'b1, addr: a, wdata: d, vld: vld});
        send_byte(8'hA5, hold);
        send_byte(8'h01, hold);
        send_byte(a, hold);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], hold);
    endtask

    task automatic send_read(input logic [7:0] a, input logic [7:0] vld);
        sb.push_back('{wr: 1'b0, addr: a, wdata: 32'd0, vld: vld});
        send_byte(8'hA5, 2);
        send_byte(8'h02, 2);
        send_byte(a, 2);
    endtask

    task automatic check_err(input string tag, input logic [1:0] code);
        chk({tag, "_err_count"}, 64'(err_seen.size()), 64'd1);
        if (err_seen.size() > 0) chk({tag, "_err_pulse_code"}, {62'd0, err_seen[0]}, {62'd0, code});
        chk({tag, "_err_code_held"}, {62'd0, bus.o_err_code}, {62'd0, code});
        err_seen.delete();
    endtask

    task automatic check_no_err(input string tag);
        chk({tag, "_no_err"}, 64'(err_seen.size()), 64'd0);
        err_seen.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, {63'd0, bus.o_cmd_valid}, 64'd0);
        chk({tag, "_write"}, {63'd0, bus.o_cmd_write}, 64'd0);
        chk({tag, "_addr"}, {56'd0, bus.o_cmd_addr}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, bus.o_cmd_wdata}, 64'd0);
        chk({tag, "_err"}, {63'd0, bus.o_err}, 64'd0);
        chk({tag, "_err_code"}, {62'd0, bus.o_err_code}, 64'd0);
    endtask

    initial begin
        int cnt;

        i_rst           = 1'b1;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_data   = 8'h00;
        bus.i_cmd_ready = 1'b1;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        tick();

        // Write frame, consumer always ready
        send_write(8'h10, 32'hDEADBEEF, 8'd1, 2);
        repeat (3) tick();
        check_no_err("write");
        chk("write_drained", 64'(sb.size()), 64'd0);

        // Read frame with 20 cycles of backpressure
        bus.i_cmd_ready = 1'b0;
        send_byte(8'hA5, 2);
        send_byte(8'h02, 2);
        sb.push_back('{wr: 1'b0, addr: 8'h3C, wdata: 32'd0, vld: 8'd21});
        bus.i_rx_data  = 8'h3C;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
        repeat (20) tick();
        chk("read_held_valid", {63'd0, bus.o_cmd_valid}, 64'd1);
        bus.i_cmd_ready = 1'b1;
        tick();
        chk("read_valid_drops", {63'd0, bus.o_cmd_valid}, 64'd0);
        chk("read_drained", 64'(sb.size()), 64'd0);
        check_no_err("read");

        // Junk byte ignored, bad command byte flagged, then a clean read
        send_byte(8'h55, 2);
        check_no_err("junk");
        send_byte(8'hA5, 2);
        send_byte(8'h07, 2);
        tick();
        check_err("badcmd", 2'b01);
        send_read(8'h01, 8'd1);
        repeat (2) tick();
        check_no_err("after_badcmd");
        chk("after_badcmd_drained", 64'(sb.size()), 64'd0);

        // Inter-byte timeout after A5 01
        send_byte(8'hA5, 2);
        bus.i_rx_data  = 8'h01;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
        cnt = 0;
        while (bus.o_err !== 1'b1 && cnt < 300) begin
            tick();
            cnt++;
        end
        chk("timeout_latency", 64'(cnt), 64'd100);
        tick();
        check_err("timeout", 2'b10);
        send_write(8'h5A, 32'h12345678, 8'd1, 2);
        repeat (2) tick();
        check_no_err("after_timeout");
        chk("after_timeout_drained", 64'(sb.size()), 64'd0);

        // Long valid levels, then a byte while the command is pending
        bus.i_cmd_ready = 1'b0;
        send_write(8'h77, 32'hCAFEF00D, 8'd0, 40);
        check_no_err("long_level");
        chk("long_level_valid", {63'd0, bus.o_cmd_valid}, 64'd1);
        send_byte(8'h99, 2);
        check_err("overrun", 2'b11);
        chk("overrun_addr_kept", {56'd0, bus.o_cmd_addr}, 64'h77);
        chk("overrun_wdata_kept", {32'd0, bus.o_cmd_wdata}, 64'hCAFEF00D);
        bus.i_cmd_ready = 1'b1;
        repeat (2) tick();
        chk("long_level_drained", 64'(sb.size()), 64'd0);

        // Byte arriving in the same cycle as the transfer
        bus.i_cmd_ready = 1'b0;
        send_read(8'h42, 8'd0);
        bus.i_cmd_ready = 1'b1;
        bus.i_rx_data   = 8'h33;
        bus.i_rx_valid  = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
        repeat (2) tick();
        check_err("xfer_overrun", 2'b11);
        chk("xfer_overrun_idle", {63'd0, bus.o_cmd_valid}, 64'd0);
        chk("xfer_overrun_drained", 64'(sb.size()), 64'd0);
        send_read(8'h43, 8'd1);
        repeat (2) tick();
        check_no_err("after_xfer_overrun");

        // Reset mid-frame, with a valid level held across reset release
        send_byte(8'hA5, 2);
        send_byte(8'h01, 2);
        send_byte(8'h10, 2);
        i_rst = 1'b1;
        #1;
        check_all_zero("midframe_reset");
        bus.i_rx_data  = 8'hA5;
        bus.i_rx_valid = 1'b1;
        #20;
        i_rst = 1'b0;
        repeat (3) tick();
        bus.i_rx_valid = 1'b0;
        tick();
        send_write(8'h21, 32'h01020304, 8'd1, 2);
        repeat (2) tick();
        check_no_err("after_reset");

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        chk("final_err_empty", 64'(err_seen.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
